// File: rtl/hazard_ctrl.sv
// Pipeline control for the 5-stage core: tracks EX/MEM/WB occupancy and derives
// stall/flush enables, load-use bubbles, registered forwarding selects and the memory hold.
module hazard_ctrl #(
   parameter int RA_W    = 5,
   parameter int FWD_EN  = 1,
   parameter int MEM_LAT = 1
) (
   input  logic            i_clk,
   input  logic            i_resetn,
   input  logic            i_id_valid,
   input  logic [RA_W-1:0] i_id_rs1,
   input  logic [RA_W-1:0] i_id_rs2,
   input  logic            i_id_uses_rs1,
   input  logic            i_id_uses_rs2,
   input  logic [RA_W-1:0] i_id_rd,
   input  logic            i_id_reg_write,
   input  logic            i_id_mem_read,
   input  logic            i_id_mem_write,
   input  logic            i_mem_branch_taken,
   output logic            o_pc_stall,
   output logic            o_ifid_stall,
   output logic            o_ifid_flush,
   output logic            o_idex_flush,
   output logic            o_exmem_flush,
   output logic            o_hold,
   output logic [1:0]      o_fwd_a,
   output logic [1:0]      o_fwd_b,
   output logic            o_ex_valid,
   output logic            o_mem_valid,
   output logic            o_wb_valid
);

   typedef enum logic [1:0] {
      FWD_IDEX  = 2'b00,
      FWD_EXMEM = 2'b01,
      FWD_MEMWB = 2'b10
   } fwd_sel_e;

   localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

   logic            r_ex_valid;
   logic [RA_W-1:0] r_ex_rd;
   logic            r_ex_rw;
   logic            r_ex_mem_rd;
   logic            r_ex_mem_op;
   logic            r_mem_valid;
   logic [RA_W-1:0] r_mem_rd;
   logic            r_mem_rw;
   logic            r_wb_valid;
   logic [3:0]      r_cnt;
   fwd_sel_e        r_fwd_a;
   fwd_sel_e        r_fwd_b;

   logic     w_hold;
   logic     w_ex_a;
   logic     w_ex_b;
   logic     w_mem_a;
   logic     w_mem_b;
   logic     w_raw_ex;
   logic     w_raw_mem;
   logic     w_load_use;
   logic     w_branch;
   logic     w_stall;
   logic     w_idex_flush;
   logic     w_adv;
   logic     w_mem_enter;
   fwd_sel_e w_fwd_a_nxt;
   fwd_sel_e w_fwd_b_nxt;

   assign w_hold = (r_cnt != '0);
   assign w_adv  = ~w_hold;

   // x0 is hard-wired, so a write to it never creates a dependency
   assign w_ex_a  = i_id_valid & i_id_uses_rs1 & (i_id_rs1 != '0) &
                    r_ex_valid & r_ex_rw & (r_ex_rd == i_id_rs1);
   assign w_ex_b  = i_id_valid & i_id_uses_rs2 & (i_id_rs2 != '0) &
                    r_ex_valid & r_ex_rw & (r_ex_rd == i_id_rs2);
   assign w_mem_a = i_id_valid & i_id_uses_rs1 & (i_id_rs1 != '0) &
                    r_mem_valid & r_mem_rw & (r_mem_rd == i_id_rs1);
   assign w_mem_b = i_id_valid & i_id_uses_rs2 & (i_id_rs2 != '0) &
                    r_mem_valid & r_mem_rw & (r_mem_rd == i_id_rs2);

   assign w_raw_ex  = w_ex_a | w_ex_b;
   assign w_raw_mem = w_mem_a | w_mem_b;

   // Without forwarding the write-through regfile still covers the WB distance
   assign w_load_use = (FWD_EN != 0) ? (w_raw_ex & r_ex_mem_rd)
                                     : (w_raw_ex | w_raw_mem);

   assign w_branch     = i_mem_branch_taken & w_adv;
   assign w_stall      = w_load_use & ~w_branch & w_adv;
   assign w_idex_flush = w_branch | w_stall;
   assign w_mem_enter  = w_adv & r_ex_valid & r_ex_mem_op & ~w_branch;

   always_comb begin
      w_fwd_a_nxt = FWD_IDEX;
      w_fwd_b_nxt = FWD_IDEX;
      if ((FWD_EN != 0) && !w_idex_flush) begin
         if (w_ex_a)       w_fwd_a_nxt = FWD_EXMEM;
         else if (w_mem_a) w_fwd_a_nxt = FWD_MEMWB;
         if (w_ex_b)       w_fwd_b_nxt = FWD_EXMEM;
         else if (w_mem_b) w_fwd_b_nxt = FWD_MEMWB;
      end
   end

   always_ff @(posedge i_clk or negedge i_resetn) begin
      if (!i_resetn) begin
         r_ex_valid  <= 1'b0;
         r_ex_rd     <= '0;
         r_ex_rw     <= 1'b0;
         r_ex_mem_rd <= 1'b0;
         r_ex_mem_op <= 1'b0;
         r_mem_valid <= 1'b0;
         r_mem_rd    <= '0;
         r_mem_rw    <= 1'b0;
         r_wb_valid  <= 1'b0;
         r_fwd_a     <= FWD_IDEX;
         r_fwd_b     <= FWD_IDEX;
      end else if (w_adv) begin
         r_ex_valid  <= i_id_valid & ~w_idex_flush;
         r_ex_rd     <= i_id_rd;
         r_ex_rw     <= i_id_reg_write;
         r_ex_mem_rd <= i_id_mem_read;
         r_ex_mem_op <= i_id_mem_read | i_id_mem_write;
         r_mem_valid <= r_ex_valid & ~w_branch;
         r_mem_rd    <= r_ex_rd;
         r_mem_rw    <= r_ex_rw;
         r_wb_valid  <= r_mem_valid;
         r_fwd_a     <= w_fwd_a_nxt;
         r_fwd_b     <= w_fwd_b_nxt;
      end
   end

   always_ff @(posedge i_clk or negedge i_resetn) begin
      if (!i_resetn) begin
         r_cnt <= '0;
      end else if (w_mem_enter) begin
         r_cnt <= LAT_M1;
      end else if (w_hold) begin
         r_cnt <= r_cnt - 4'd1;
      end
   end

   // Combinational enables are forced low while reset is asserted
   always_comb begin
      o_pc_stall    = i_resetn & w_stall;
      o_ifid_stall  = i_resetn & w_stall;
      o_ifid_flush  = i_resetn & w_branch;
      o_idex_flush  = i_resetn & w_idex_flush;
      o_exmem_flush = i_resetn & w_branch;
      o_hold        = w_hold;
   end

   assign o_fwd_a     = r_fwd_a;
   assign o_fwd_b     = r_fwd_b;
   assign o_ex_valid  = r_ex_valid;
   assign o_mem_valid = r_mem_valid;
   assign o_wb_valid  = r_wb_valid;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: four parameter variants driven in lockstep,
// each compared every cycle against an instruction-level pipeline model.
module tb_hazard_ctrl;

   localparam int N = 4;

   typedef struct packed {
      logic       v;
      logic [4:0] rd;
      logic       rw;
      logic       ld;
      logic       mop;
   } ins_t;

   typedef struct packed {
      logic       rn;
      logic       v;
      logic [4:0] rs1;
      logic       u1;
      logic [4:0] rs2;
      logic       u2;
      logic [4:0] rd;
      logic       rw;
      logic       mr;
      logic       mw;
      logic       br;
   } stim_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       resetn;
   logic       id_valid, u1, u2, rw, mr, mw, br;
   logic [4:0] rs1, rs2, rd;

   logic [N-1:0] pc_stall, ifid_stall, ifid_flush, idex_flush, exmem_flush, hold;
   logic [N-1:0] ex_v, mem_v, wb_v;
   logic [1:0]   fwd_a [N];
   logic [1:0]   fwd_b [N];

   // 0: fwd, lat1   1: no fwd, lat1   2: fwd, lat3   3: fwd, lat4
   for (genvar g = 0; g < N; g++) begin : g_dut
      hazard_ctrl #(
         .RA_W   (5),
         .FWD_EN ((g == 1) ? 0 : 1),
         .MEM_LAT((g == 2) ? 3 : ((g == 3) ? 4 : 1))
      ) u_dut (
         .i_clk             (clk),
         .i_resetn          (resetn),
         .i_id_valid        (id_valid),
         .i_id_rs1          (rs1),
         .i_id_rs2          (rs2),
         .i_id_uses_rs1     (u1),
         .i_id_uses_rs2     (u2),
         .i_id_rd           (rd),
         .i_id_reg_write    (rw),
         .i_id_mem_read     (mr),
         .i_id_mem_write    (mw),
         .i_mem_branch_taken(br),
         .o_pc_stall        (pc_stall[g]),
         .o_ifid_stall      (ifid_stall[g]),
         .o_ifid_flush      (ifid_flush[g]),
         .o_idex_flush      (idex_flush[g]),
         .o_exmem_flush     (exmem_flush[g]),
         .o_hold            (hold[g]),
         .o_fwd_a           (fwd_a[g]),
         .o_fwd_b           (fwd_b[g]),
         .o_ex_valid        (ex_v[g]),
         .o_mem_valid       (mem_v[g]),
         .o_wb_valid        (wb_v[g])
      );
   end

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic fwd_of(int k);
      return (k != 1);
   endfunction

   function automatic int unsigned lat_of(int k);
      return (k == 2) ? 3 : ((k == 3) ? 4 : 1);
   endfunction

   // Model: the instruction occupying each stage, plus cycles spent so far in MEM
   ins_t        m_ex  [N];
   ins_t        m_mem [N];
   ins_t        m_wb  [N];
   int unsigned m_age [N];
   logic [1:0]  m_fa  [N];
   logic [1:0]  m_fb  [N];
   logic [5:0]  obs_ctrl [N];

   function automatic logic hit(ins_t s, logic [4:0] rs, logic use_rs);
      return id_valid && use_rs && (rs != 5'd0) && s.v && s.rw && (s.rd == rs);
   endfunction

   function automatic logic m_hold(int k);
      return m_mem[k].v && m_mem[k].mop && (m_age[k] < lat_of(k));
   endfunction

   function automatic logic m_lu(int k);
      logic e, m;
      e = hit(m_ex[k], rs1, u1) || hit(m_ex[k], rs2, u2);
      m = hit(m_mem[k], rs1, u1) || hit(m_mem[k], rs2, u2);
      if (fwd_of(k)) return e && m_ex[k].ld;
      return e || m;
   endfunction

   function automatic logic [5:0] m_ctrl(int k);
      logic h, b, s;
      h = m_hold(k);
      b = br && !h;
      s = m_lu(k) && !b && !h;
      if (!resetn) return 6'b0;
      return {s, s, b, b | s, b, h};
   endfunction

   function automatic logic [1:0] m_sel(int k, logic e, logic m, logic bub);
      if (bub || !fwd_of(k)) return 2'd0;
      if (e) return 2'd1;
      if (m) return 2'd2;
      return 2'd0;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < N; k++) begin
         m_ex[k]  = '0;
         m_mem[k] = '0;
         m_wb[k]  = '0;
         m_age[k] = 0;
         m_fa[k]  = 2'd0;
         m_fb[k]  = 2'd0;
      end
   endtask

   task automatic model_step();
      for (int k = 0; k < N; k++) begin
         logic b, bub, ea, eb, ma, mb;
         ins_t nx;
         if (m_hold(k)) begin
            m_age[k]++;
         end else begin
            b   = br;
            bub = b || m_lu(k);
            ea  = hit(m_ex[k], rs1, u1);
            eb  = hit(m_ex[k], rs2, u2);
            ma  = hit(m_mem[k], rs1, u1);
            mb  = hit(m_mem[k], rs2, u2);
            m_fa[k]  = m_sel(k, ea, ma, bub);
            m_fb[k]  = m_sel(k, eb, mb, bub);
            m_wb[k]  = m_mem[k];
            m_mem[k] = b ? '0 : m_ex[k];
            m_age[k] = 1;
            nx.v   = id_valid;
            nx.rd  = rd;
            nx.rw  = rw;
            nx.ld  = mr;
            nx.mop = mr | mw;
            m_ex[k] = bub ? '0 : nx;
         end
      end
   endtask

   task automatic do_cycle(input stim_t s);
      resetn   = s.rn;
      id_valid = s.v;
      rs1 = s.rs1; u1 = s.u1;
      rs2 = s.rs2; u2 = s.u2;
      rd  = s.rd;  rw = s.rw;
      mr  = s.mr;  mw = s.mw;
      br  = s.br;
      if (!s.rn) model_reset();
      @(negedge clk);
      for (int k = 0; k < N; k++) begin
         obs_ctrl[k] = {pc_stall[k], ifid_stall[k], ifid_flush[k],
                        idex_flush[k], exmem_flush[k], hold[k]};
         chk($sformatf("ctrl%0d", k), obs_ctrl[k], m_ctrl(k));
         chk($sformatf("fwd%0d", k), {fwd_a[k], fwd_b[k]}, {m_fa[k], m_fb[k]});
         chk($sformatf("valid%0d", k), {ex_v[k], mem_v[k], wb_v[k]},
             {m_ex[k].v, m_mem[k].v, m_wb[k].v});
      end
      @(posedge clk);
      if (resetn) model_step();
      #1;
   endtask

   function automatic stim_t nop();
      stim_t s;
      s    = '0;
      s.rn = 1'b1;
      return s;
   endfunction

   function automatic stim_t ins(logic [4:0] d, logic [4:0] a, logic ua, logic [4:0] b,
                                 logic ub, logic w, logic r, logic st);
      stim_t s;
      s     = nop();
      s.v   = 1'b1;
      s.rd  = d;  s.rw = w;
      s.rs1 = a;  s.u1 = ua;
      s.rs2 = b;  s.u2 = ub;
      s.mr  = r;  s.mw = st;
      return s;
   endfunction

   task automatic drain(input int n);
      for (int i = 0; i < n; i++) do_cycle(nop());
   endtask

   initial begin
      stim_t s;
      int    cnt_a, cnt_b, cnt_c, cnt_d;

      model_reset();
      do_cycle('0);

      // Reset held with random inputs: everything reads zero
      for (int i = 0; i < 6; i++) begin
         s    = stim_t'($bits(stim_t)'($urandom));
         s.rn = 1'b0;
         do_cycle(s);
         chk("rst_out", {pc_stall, ifid_stall, ifid_flush, idex_flush, exmem_flush,
                         hold, ex_v, mem_v, wb_v}, 64'd0);
         chk("rst_fwd", {fwd_a[0], fwd_a[1], fwd_a[2], fwd_a[3],
                         fwd_b[0], fwd_b[1], fwd_b[2], fwd_b[3]}, 64'd0);
      end
      do_cycle(ins(5'd3, 5'd1, 1'b1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0));
      chk("rel_exv", ex_v[0], 1'b1);
      drain(4);

      // Forwarding distances
      do_cycle(ins(5'd5, 5'd1, 1'b1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0));
      do_cycle(ins(5'd6, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0));
      chk("fwd_ex", fwd_a[0], 2'd1);
      drain(4);
      do_cycle(ins(5'd5, 5'd1, 1'b1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0));
      do_cycle(nop());
      do_cycle(ins(5'd6, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0));
      chk("fwd_mem", fwd_a[0], 2'd2);
      drain(4);
      do_cycle(ins(5'd0, 5'd1, 1'b1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0));
      do_cycle(ins(5'd6, 5'd0, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0));
      chk("fwd_x0", fwd_a[0], 2'd0);
      drain(4);
      do_cycle(ins(5'd5, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0));
      do_cycle(ins(5'd5, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0));
      do_cycle(ins(5'd6, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0));
      chk("fwd_pri", fwd_a[0], 2'd1);
      drain(4);

      // Load-use: one bubble with forwarding, two without
      cnt_a = 0;
      cnt_b = 0;
      do_cycle(ins(5'd7, 5'd1, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0));
      for (int i = 0; i < 3; i++) begin
         do_cycle(ins(5'd8, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0));
         cnt_a += int'(obs_ctrl[0][5]);
         cnt_b += int'(obs_ctrl[1][5]);
         if (i == 1) chk("fwd_ld", fwd_b[0], 2'd2);
      end
      chk("lu_fwd", cnt_a, 1);
      chk("lu_nofwd", cnt_b, 2);
      drain(6);

      // Branch flush overrides a coincident load-use stall
      do_cycle(ins(5'd7, 5'd1, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0));
      s    = ins(5'd8, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0);
      s.br = 1'b1;
      do_cycle(s);
      chk("br_ctrl", obs_ctrl[0], 6'b001110);
      chk("br_valid", {ex_v[0], mem_v[0]}, 2'b00);
      drain(6);

      // Multi-cycle MEM: hold length per latency, branch during hold ignored
      cnt_c = 0;
      cnt_d = 0;
      for (int j = 0; j < 8; j++) begin
         s = (j == 0) ? ins(5'd9, 5'd1, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0) : nop();
         if (j == 3) s.br = 1'b1;
         do_cycle(s);
         cnt_c += int'(obs_ctrl[2][0]);
         cnt_d += int'(obs_ctrl[3][0]);
         if (j == 3) chk("hold_br", obs_ctrl[2][3:1], 3'b000);
      end
      chk("hold_lat3", cnt_c, 2);
      chk("hold_lat4", cnt_d, 3);
      drain(4);

      // Reset in the first hold cycle ends the hold at once
      do_cycle(ins(5'd9, 5'd1, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0));
      do_cycle(nop());
      s    = nop();
      s.rn = 1'b0;
      do_cycle(s);
      chk("rst_hold", obs_ctrl[3][0], 1'b0);
      do_cycle(nop());
      cnt_d = 0;
      for (int j = 0; j < 8; j++) begin
         s = (j == 0) ? ins(5'd9, 5'd1, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1) : nop();
         do_cycle(s);
         cnt_d += int'(obs_ctrl[3][0]);
      end
      chk("hold_after_rst", cnt_d, 3);

      // Random traffic over a small register set to provoke hazards
      for (int i = 0; i < 2000; i++) begin
         s     = stim_t'($bits(stim_t)'($urandom));
         s.rn  = ($urandom_range(0, 199) != 0);
         s.v   = ($urandom_range(0, 7) != 0);
         s.rs1 = 5'($urandom_range(0, 3));
         s.rs2 = 5'($urandom_range(0, 3));
         s.rd  = 5'($urandom_range(0, 3));
         s.br  = ($urandom_range(0, 9) == 0);
         do_cycle(s);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
